// File: rtl/nibble_sel_pkg.sv
// Shared definitions for the nibble selector pipeline: per-lane mode
// encodings and the width of the accepted-request counter.
package nibble_sel_pkg;

  typedef enum logic [1:0] {
    MODE_A    = 2'b00,
    MODE_B    = 2'b01,
    MODE_ZERO = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/nibble_lane_mux.sv
// One output lane of the nibble selector: picks a field from source A or B,
// forces zero, or repeats the lane's previous value. Purely combinational.
module nibble_lane_mux
  import nibble_sel_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NIB_W  = 4,
  parameter int IDX_W  = $clog2(DATA_W / NIB_W)
) (
  input  logic [DATA_W-1:0] data_a_i,
  input  logic [DATA_W-1:0] data_b_i,
  input  logic [IDX_W-1:0]  sel_a_i,
  input  logic [IDX_W-1:0]  sel_b_i,
  input  logic [1:0]        mode_i,
  input  logic [NIB_W-1:0]  last_i,
  output logic [NIB_W-1:0]  lane_o
);

  // Lane value selection; every index is in range because the field count is a power of two
  always_comb begin
    lane_o = '0;
    case (mode_e'(mode_i))
      MODE_A:    lane_o = data_a_i[int'(sel_a_i) * NIB_W +: NIB_W];
      MODE_B:    lane_o = data_b_i[int'(sel_b_i) * NIB_W +: NIB_W];
      MODE_ZERO: lane_o = '0;
      MODE_HOLD: lane_o = last_i;
    endcase
  end

endmodule

// File: rtl/nibble_selector_pipe.sv
// Parametrised nibble selector with a 2-entry output buffer and valid/ready
// handshakes on both sides. Feeds the downstream byte/nibble packer from the
// register-file read ports. Outputs depend only on registers.
module nibble_selector_pipe
  import nibble_sel_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NIB_W  = 4,
  parameter int LANES  = 4,
  parameter int IDX_W  = $clog2(DATA_W / NIB_W)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_W-1:0]       data_a_i,
  input  logic [DATA_W-1:0]       data_b_i,
  input  logic [LANES*IDX_W-1:0]  sel_a_i,
  input  logic [LANES*IDX_W-1:0]  sel_b_i,
  input  logic [LANES*2-1:0]      mode_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*NIB_W-1:0]  data_out_o,
  output logic [XFER_CNT_W-1:0]   xfer_cnt_o
);

  localparam int OUT_W = LANES * NIB_W;

  logic [OUT_W-1:0]      laneVal;
  logic [OUT_W-1:0]      lastQ, lastD;
  logic [OUT_W-1:0]      bufQ [2];
  logic [OUT_W-1:0]      bufD [2];
  logic                  wrPtrQ, wrPtrD;
  logic                  rdPtrQ, rdPtrD;
  logic [1:0]            countQ, countD;
  logic                  inReadyQ, inReadyD;
  logic [XFER_CNT_W-1:0] xferCntQ, xferCntD;
  logic                  accept;
  logic                  pop;

  for (genvar g = 0; g < LANES; g++) begin : gLane
    nibble_lane_mux #(
      .DATA_W (DATA_W),
      .NIB_W  (NIB_W),
      .IDX_W  (IDX_W)
    ) uLaneMux (
      .data_a_i (data_a_i),
      .data_b_i (data_b_i),
      .sel_a_i  (sel_a_i[g*IDX_W +: IDX_W]),
      .sel_b_i  (sel_b_i[g*IDX_W +: IDX_W]),
      .mode_i   (mode_i[g*2 +: 2]),
      .last_i   (lastQ[g*NIB_W +: NIB_W]),
      .lane_o   (laneVal[g*NIB_W +: NIB_W])
    );
  end

  assign accept      = in_valid_i & inReadyQ;
  assign pop         = (countQ != 2'd0) & out_ready_i;
  assign in_ready_o  = inReadyQ;
  assign out_valid_o = (countQ != 2'd0);
  assign data_out_o  = (countQ != 2'd0) ? bufQ[rdPtrQ] : '0;
  assign xfer_cnt_o  = xferCntQ;

  // Next state: LAST tracks every accepted lane value, the FIFO pushes on accept and pops on
  // consumer handshake, ready is decoded from the next count so it is a plain register output
  always_comb begin
    lastD    = lastQ;
    bufD     = bufQ;
    wrPtrD   = wrPtrQ;
    rdPtrD   = rdPtrQ;
    countD   = countQ;
    xferCntD = xferCntQ;

    if (accept) begin
      lastD          = laneVal;
      bufD[wrPtrQ]   = laneVal;
      wrPtrD         = ~wrPtrQ;
      if (xferCntQ != '1) begin
        xferCntD = xferCntQ + 1'b1;
      end
    end

    if (pop) begin
      rdPtrD = ~rdPtrQ;
    end

    case ({accept, pop})
      2'b10:   countD = countQ + 2'd1;
      2'b01:   countD = countQ - 2'd1;
      default: countD = countQ;
    endcase

    inReadyD = (countD != 2'd2);
  end

  // State registers; reset empties the buffer and clears history and counter immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lastQ    <= '0;
      bufQ[0]  <= '0;
      bufQ[1]  <= '0;
      wrPtrQ   <= 1'b0;
      rdPtrQ   <= 1'b0;
      countQ   <= 2'd0;
      inReadyQ <= 1'b1;
      xferCntQ <= '0;
    end else begin
      lastQ    <= lastD;
      bufQ[0]  <= bufD[0];
      bufQ[1]  <= bufD[1];
      wrPtrQ   <= wrPtrD;
      rdPtrQ   <= rdPtrD;
      countQ   <= countD;
      inReadyQ <= inReadyD;
      xferCntQ <= xferCntD;
    end
  end

endmodule

// File: tb/tb_nibble_selector_pipe.sv
// Directed testbench for nibble_selector_pipe with hand-computed expectations.
module tb_nibble_selector_pipe;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [11:0] selA;
  logic [11:0] selB;
  logic [7:0]  mode;
  logic        outValid;
  logic        outReady;
  logic [15:0] dataOut;
  logic [15:0] xferCnt;

  int checkCount = 0;
  int passCount  = 0;

  nibble_selector_pipe #(
    .DATA_W (32),
    .NIB_W  (4),
    .LANES  (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .data_a_i    (dataA),
    .data_b_i    (dataB),
    .sel_a_i     (selA),
    .sel_b_i     (selB),
    .mode_i      (mode),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .data_out_o  (dataOut),
    .xfer_cnt_o  (xferCnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic [11:0] sa, input logic [11:0] sb,
                               input logic [7:0] m, input logic ordy);
    inValid  = v;
    dataA    = a;
    dataB    = b;
    selA     = sa;
    selB     = sb;
    mode     = m;
    outReady = ordy;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 12'h0, 12'h0, 8'h00, 1'b1);
    repeat (2) stepEdge();
    checkOutput("reset_out_valid", outValid, 0);
    checkOutput("reset_in_ready", inReady, 1);
    checkOutput("reset_data_out", dataOut, 0);
    checkOutput("reset_xfer_cnt", xferCnt, 0);
    rst = 1'b0;

    // Test 1: all lanes from A, indices {7,0,3,5}
    applyStimulus(1'b1, 32'h76543210, 32'h0, {3'd7, 3'd0, 3'd3, 3'd5}, 12'h0, 8'h00, 1'b1);
    stepEdge();
    applyStimulus(1'b0, 32'h76543210, 32'h0, {3'd7, 3'd0, 3'd3, 3'd5}, 12'h0, 8'h00, 1'b1);
    checkOutput("t1_out_valid", outValid, 1);
    checkOutput("t1_data_out", dataOut, 32'h7035);
    checkOutput("t1_xfer_cnt", xferCnt, 1);
    stepEdge();
    checkOutput("t1_drained_valid", outValid, 0);
    checkOutput("t1_drained_data", dataOut, 0);

    // Test 2: lanes {B, ZERO, A, HOLD}
    applyStimulus(1'b1, 32'h76543210, 32'hFEDCBA98, {3'd7, 3'd0, 3'd3, 3'd5},
                  {3'd2, 3'd0, 3'd0, 3'd0}, {2'b01, 2'b10, 2'b00, 2'b11}, 1'b1);
    stepEdge();
    inValid = 1'b0;
    checkOutput("t2_data_out", dataOut, 32'hA035);
    checkOutput("t2_xfer_cnt", xferCnt, 2);
    stepEdge();

    // All lanes HOLD repeats the previous result
    applyStimulus(1'b1, 32'h0, 32'h0, 12'h0, 12'h0, 8'hFF, 1'b1);
    stepEdge();
    inValid = 1'b0;
    checkOutput("hold_all_data", dataOut, 32'hA035);
    checkOutput("hold_all_xfer", xferCnt, 3);
    stepEdge();
    checkOutput("hold_ignored_valid0", xferCnt, 3);

    // Test 3: backpressure, three requests against a stalled consumer
    pulseReset();
    checkOutput("t3_reset_xfer", xferCnt, 0);
    applyStimulus(1'b1, 32'h76543210, 32'h0, {3'd0, 3'd1, 3'd2, 3'd3}, 12'h0, 8'h00, 1'b0);
    stepEdge();
    checkOutput("t3_ready_after_1", inReady, 1);
    checkOutput("t3_data_after_1", dataOut, 32'h0123);
    selA = {3'd4, 3'd5, 3'd6, 3'd7};
    stepEdge();
    checkOutput("t3_ready_after_2", inReady, 0);
    checkOutput("t3_xfer_after_2", xferCnt, 2);
    checkOutput("t3_data_after_2", dataOut, 32'h0123);
    selA = {3'd7, 3'd6, 3'd5, 3'd4};
    stepEdge();
    checkOutput("t3_third_held_xfer", xferCnt, 2);
    checkOutput("t3_stall_data", dataOut, 32'h0123);
    checkOutput("t3_stall_valid", outValid, 1);
    checkOutput("t3_stall_ready", inReady, 0);

    // Test 4: release the consumer with the third request still offered
    outReady = 1'b1;
    stepEdge();
    checkOutput("t4_second_data", dataOut, 32'h4567);
    checkOutput("t4_ready_rises", inReady, 1);
    checkOutput("t4_xfer_no_push", xferCnt, 2);
    stepEdge();
    inValid = 1'b0;
    checkOutput("t4_third_data", dataOut, 32'h7654);
    checkOutput("t4_third_xfer", xferCnt, 3);
    checkOutput("t4_pushpop_ready", inReady, 1);
    stepEdge();
    checkOutput("t4_empty_valid", outValid, 0);
    checkOutput("t4_empty_data", dataOut, 0);

    // Test 5: asynchronous reset with a full buffer
    applyStimulus(1'b1, 32'h76543210, 32'h0, {3'd4, 3'd5, 3'd6, 3'd7}, 12'h0, 8'h00, 1'b0);
    stepEdge();
    stepEdge();
    checkOutput("t5_full_ready", inReady, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_async_valid", outValid, 0);
    checkOutput("t5_async_data", dataOut, 0);
    checkOutput("t5_async_ready", inReady, 1);
    checkOutput("t5_async_xfer", xferCnt, 0);
    rst = 1'b0;
    applyStimulus(1'b1, 32'h76543210, 32'hFEDCBA98, 12'hFFF, 12'hFFF, 8'hFF, 1'b1);
    stepEdge();
    inValid = 1'b0;
    checkOutput("t5_hold_after_reset", dataOut, 32'h0000);
    checkOutput("t5_hold_valid", outValid, 1);
    stepEdge();

    // Test 6: counter saturation
    pulseReset();
    applyStimulus(1'b1, 32'h76543210, 32'h0, {3'd1, 3'd2, 3'd3, 3'd4}, 12'h0, 8'h00, 1'b1);
    repeat (65534) @(posedge clk);
    #1;
    checkOutput("t6_xfer_fffe", xferCnt, 32'hFFFE);
    checkOutput("t6_stream_data", dataOut, 32'h1234);
    stepEdge();
    checkOutput("t6_xfer_ffff", xferCnt, 32'hFFFF);
    repeat (3) stepEdge();
    checkOutput("t6_xfer_no_wrap", xferCnt, 32'hFFFF);
    inValid = 1'b0;
    stepEdge();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
